// File: rtl/uart_link.sv
`default_nettype none
// ============================================================================
// Module   : uart_link
// Purpose  : 8N1 UART with multi-byte word TX and FWFT byte FIFO on RX.
// Revision : 1.0
// ============================================================================
module uart_link #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int WORD_BYTES = 8,
  parameter int RX_DEPTH   = 16,
  localparam int LW        = $clog2(WORD_BYTES + 1)
) (
  input  logic                    CLK100MHZ,
  input  logic                    rst_n,
  input  logic                    rx_pin_in,
  output logic                    tx_pin_out,
  input  logic [8*WORD_BYTES-1:0] tx_word,
  input  logic [LW-1:0]           tx_len,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [7:0]              rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic                    rx_frame_err,
  output logic                    rx_overflow
);

  localparam int             DIV      = CLK_HZ / BAUD;
  localparam int             CW       = $clog2(DIV);
  localparam int             AW       = $clog2(RX_DEPTH);
  localparam logic [CW-1:0]  BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0]  HALF_END = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------------------------------------------------------- TX
  state_t                  tx_state_q, tx_state_d;
  logic [CW-1:0]           tx_cnt_q, tx_cnt_d;
  logic [2:0]              tx_bit_q, tx_bit_d;
  logic [8*WORD_BYTES-1:0] tx_word_q, tx_word_d;
  logic [LW-1:0]           tx_left_q, tx_left_d;
  logic                    tx_hold_q, tx_hold_d;
  logic [LW-1:0]           tx_len_clamped;
  logic                    tx_tick;

  assign tx_len_clamped = (tx_len > LW'(WORD_BYTES)) ? LW'(WORD_BYTES) : tx_len;
  assign tx_tick        = (tx_cnt_q == BIT_END);
  // tx_hold_q models the single busy cycle of a zero-length word
  assign tx_ready       = (tx_state_q == IDLE) && !tx_hold_q;

  always_comb begin
    tx_pin_out = 1'b1;
    case (tx_state_q)
      START:   tx_pin_out = 1'b0;
      DATA:    tx_pin_out = tx_word_q[0];
      default: tx_pin_out = 1'b1;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_word_d  = tx_word_q;
    tx_left_d  = tx_left_q;
    tx_hold_d  = 1'b0;
    case (tx_state_q)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          tx_word_d = tx_word;
          tx_left_d = tx_len_clamped;
          tx_cnt_d  = '0;
          tx_bit_d  = '0;
          if (tx_len_clamped != '0) tx_state_d = START;
          else                      tx_hold_d  = 1'b1;
        end
      end
      START: begin
        tx_cnt_d = tx_tick ? '0 : tx_cnt_q + CW'(1);
        if (tx_tick) tx_state_d = DATA;
      end
      DATA: begin
        tx_cnt_d = tx_tick ? '0 : tx_cnt_q + CW'(1);
        if (tx_tick) begin
          // shifting the whole word brings the next byte down to [7:0]
          tx_word_d = tx_word_q >> 1;
          if (tx_bit_q == 3'd7) begin
            tx_bit_d   = '0;
            tx_left_d  = tx_left_q - LW'(1);
            tx_state_d = STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        tx_cnt_d = tx_tick ? '0 : tx_cnt_q + CW'(1);
        if (tx_tick) tx_state_d = (tx_left_q != '0) ? START : IDLE;
      end
      default: tx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_word_q  <= '0;
      tx_left_q  <= '0;
      tx_hold_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_word_q  <= tx_word_d;
      tx_left_q  <= tx_left_d;
      tx_hold_q  <= tx_hold_d;
    end
  end

  // ---------------------------------------------------------------- RX
  state_t        rx_state_q, rx_state_d;
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_ferr_q, rx_ferr_d;
  logic          rx_ovf_q, rx_ovf_d;
  logic          rx_push, rx_tick;

  assign rx_tick = (rx_cnt_q == BIT_END);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_ferr_d  = 1'b0;
    rx_push    = 1'b0;
    case (rx_state_q)
      IDLE: begin
        // rx_prev_q resets low, so a line held low through reset is not a start
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = START;
          rx_cnt_d   = '0;
        end
      end
      START: begin
        rx_cnt_d = rx_cnt_q + CW'(1);
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        rx_cnt_d = rx_tick ? '0 : rx_cnt_q + CW'(1);
        if (rx_tick) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = STOP;
        end
      end
      STOP: begin
        rx_cnt_d = rx_tick ? '0 : rx_cnt_q + CW'(1);
        if (rx_tick) begin
          rx_push    = rx_s2_q;
          rx_ferr_d  = !rx_s2_q;
          rx_state_d = IDLE;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0] mem_q [RX_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        fifo_empty, fifo_full, fifo_pop, fifo_wr;

  assign fifo_empty = (wr_q == rd_q);
  assign fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign fifo_pop   = !fifo_empty && rx_ready;
  // a simultaneous pop frees the slot the push lands in, even when full
  assign fifo_wr    = rx_push && (!fifo_full || fifo_pop);
  assign rx_ovf_d   = rx_push && fifo_full && !fifo_pop;

  assign rx_valid     = !fifo_empty;
  assign rx_data      = fifo_empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
  assign rx_frame_err = rx_ferr_q;
  assign rx_overflow  = rx_ovf_q;

  always_ff @(posedge CLK100MHZ) begin
    if (fifo_wr) mem_q[wr_q[AW-1:0]] <= rx_shift_q;
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b0;
      rx_s2_q    <= 1'b0;
      rx_prev_q  <= 1'b0;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_ferr_q  <= 1'b0;
      rx_ovf_q   <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      rx_s1_q    <= rx_pin_in;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovf_q   <= rx_ovf_d;
      if (fifo_wr)  wr_q <= wr_q + (AW+1)'(1);
      if (fifo_pop) rd_q <= rd_q + (AW+1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_link.sv
`default_nettype none
// Directed self-checking bench for uart_link at DIV=10, RX_DEPTH=4.
module tb_uart_link;
  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_pin = 1'b1;
  logic        tx_pin;
  logic [63:0] tx_word = '0;
  logic [3:0]  tx_len = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        rx_ferr;
  logic        rx_ovf;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;

  uart_link #(
    .CLK_HZ(100_000_000), .BAUD(10_000_000), .WORD_BYTES(8), .RX_DEPTH(4)
  ) dut (
    .CLK100MHZ(clk), .rst_n(rst_n), .rx_pin_in(rx_pin), .tx_pin_out(tx_pin),
    .tx_word(tx_word), .tx_len(tx_len), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_frame_err(rx_ferr), .rx_overflow(rx_ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_ferr) ferr_cnt++;
    if (rx_ovf)  ovf_cnt++;
  end

  // Expected line level k cycles after acceptance (k >= 1).
  function automatic logic exp_line(input logic [63:0] w, input int k);
    int idx, b, p;
    idx = (k - 1) / DIV;
    b = idx / 10;
    p = idx % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return w[b*8 + p - 1];
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx_pin = 1'b0;
    repeat (DIV) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
    rx_pin = stop;
    repeat (DIV) @(posedge clk);
    #1;
    rx_pin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pop;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic test_reset;
    rx_pin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx_pin !== 1'b1) begin errors++; $display("FAIL rst_tx_pin: got %b want 1", tx_pin); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data: got %h want 00", rx_data); end
    checks++; if (rx_ferr !== 1'b0 || rx_ovf !== 1'b0) begin errors++; $display("FAIL rst_pulses: got ferr=%b ovf=%b want 0 0", rx_ferr, rx_ovf); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rel_tx_ready: got %b want 1", tx_ready); end
    // line held low across release must not produce a start
    repeat (30) @(posedge clk);
    #1;
    rx_pin = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    checks++; if (rx_valid !== 1'b0 || ferr_cnt != 0) begin errors++; $display("FAIL rel_low_line: got valid=%b ferr=%0d want 0 0", rx_valid, ferr_cnt); end
  endtask

  task automatic test_tx_basic;
    int bad = 0, first = 0;
    logic [63:0] w = 64'h0807060504030201;
    tx_word = w; tx_len = 4'd3; tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      if (tx_pin !== exp_line(w, k) || tx_ready !== 1'b0) begin
        if (bad == 0) first = k;
        bad++;
      end
      @(posedge clk);
      #1;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL tx_basic_line: got %0d bad cycles (first %0d) want 0", bad, first); end
    checks++; if (tx_ready !== 1'b1 || tx_pin !== 1'b1) begin errors++; $display("FAIL tx_basic_ready301: got ready=%b pin=%b want 1 1", tx_ready, tx_pin); end
  endtask

  task automatic test_tx_zero;
    int bad = 0;
    tx_word = 64'hFFFF_0000_FFFF_0000; tx_len = 4'd0; tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (tx_pin !== 1'b1) bad++;
      if (k == 2) begin
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL tx_zero_ready: got %b want 1", tx_ready); end
      end
      @(posedge clk);
      #1;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL tx_zero_line: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_tx_clamp;
    int bad = 0, first = 0;
    logic [63:0] w = 64'hF00F_5AA5_C33C_8118;
    tx_word = w; tx_len = 4'd12; tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    for (int k = 1; k <= 800; k++) begin
      if (tx_pin !== exp_line(w, k) || tx_ready !== 1'b0) begin
        if (bad == 0) first = k;
        bad++;
      end
      @(posedge clk);
      #1;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL tx_clamp_line: got %0d bad cycles (first %0d) want 0", bad, first); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL tx_clamp_ready801: got %b want 1", tx_ready); end
  endtask

  task automatic test_rx_order;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin errors++; $display("FAIL rx_head: got valid=%b data=%h want 1 a5", rx_valid, rx_data); end
    pop();
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin errors++; $display("FAIL rx_second: got valid=%b data=%h want 1 3c", rx_valid, rx_data); end
    pop();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_drained: got valid=%b want 0", rx_valid); end
  endtask

  task automatic test_rx_overflow;
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int o0 = ovf_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    send_frame(8'h55, 1'b1);
    checks++; if (ovf_cnt - o0 != 1) begin errors++; $display("FAIL rx_ovf_pulse: got %0d pulses want 1", ovf_cnt - o0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_valid !== 1'b1 || rx_data !== exp[i]) begin errors++; $display("FAIL rx_ovf_data%0d: got valid=%b data=%h want 1 %h", i, rx_valid, rx_data, exp[i]); end
      pop();
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_ovf_empty: got valid=%b want 0", rx_valid); end
  endtask

  task automatic test_rx_pop_full;
    logic [7:0] exp [4] = '{8'h62, 8'h63, 8'h64, 8'h65};
    int o0 = ovf_cnt;
    send_frame(8'h61, 1'b1);
    send_frame(8'h62, 1'b1);
    send_frame(8'h63, 1'b1);
    send_frame(8'h64, 1'b1);
    // pop lands on the same edge as the stop-bit push of the 5th frame
    fork
      send_frame(8'h65, 1'b1);
      begin
        repeat (97) @(posedge clk);
        #1;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
      end
    join
    checks++; if (ovf_cnt != o0) begin errors++; $display("FAIL rx_popfull_ovf: got %0d pulses want 0", ovf_cnt - o0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_valid !== 1'b1 || rx_data !== exp[i]) begin errors++; $display("FAIL rx_popfull_data%0d: got valid=%b data=%h want 1 %h", i, rx_valid, rx_data, exp[i]); end
      pop();
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_popfull_empty: got valid=%b want 0", rx_valid); end
  endtask

  task automatic test_rx_errors;
    int f0 = ferr_cnt;
    rx_pin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_pin = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    checks++; if (rx_valid !== 1'b0 || ferr_cnt != f0) begin errors++; $display("FAIL rx_glitch: got valid=%b ferr=%0d want 0 0", rx_valid, ferr_cnt - f0); end
    send_frame(8'h5A, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (ferr_cnt - f0 != 1 || rx_valid !== 1'b0) begin errors++; $display("FAIL rx_frame_err: got pulses=%0d valid=%b want 1 0", ferr_cnt - f0, rx_valid); end
    send_frame(8'h7E, 1'b1);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h7E) begin errors++; $display("FAIL rx_after_err: got valid=%b data=%h want 1 7e", rx_valid, rx_data); end
  endtask

  task automatic test_tx_reset;
    int bad = 0, first = 0;
    logic [63:0] w = 64'h0000_0000_0000_0096;
    tx_word = 64'h0000_0000_0000_55C3; tx_len = 4'd2; tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (54) @(posedge clk);
    #3;
    // cycle 55 carries data bit 4 of 8'hC3, which is 0
    checks++; if (tx_pin !== 1'b0) begin errors++; $display("FAIL txrst_midbit: got %b want 0", tx_pin); end
    rst_n = 1'b0;
    #1;
    checks++; if (tx_pin !== 1'b1 || tx_ready !== 1'b1 || rx_valid !== 1'b0) begin errors++; $display("FAIL txrst_async: got pin=%b ready=%b rxv=%b want 1 1 0", tx_pin, tx_ready, rx_valid); end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (tx_pin !== 1'b1 || tx_ready !== 1'b1) begin errors++; $display("FAIL txrst_release: got pin=%b ready=%b want 1 1", tx_pin, tx_ready); end
    tx_word = w; tx_len = 4'd1; tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (tx_pin !== exp_line(w, k) || tx_ready !== 1'b0) begin
        if (bad == 0) first = k;
        bad++;
      end
      @(posedge clk);
      #1;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL txrst_new_line: got %0d bad cycles (first %0d) want 0", bad, first); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL txrst_new_ready: got %b want 1", tx_ready); end
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_zero();
    test_tx_clamp();
    test_rx_order();
    test_rx_overflow();
    test_rx_pop_full();
    test_rx_errors();
    test_tx_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_link.md
UART_LINK -- requirements
Module: uart_link

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115_200, line bit rate; DIV = CLK_HZ/BAUD (integer, truncated), DIV >= 4.
REQ-003 SHALL have parameter WORD_BYTES, default 8, maximum bytes per TX word; LW = $clog2(WORD_BYTES+1).
REQ-004 SHALL have parameter RX_DEPTH, default 16, RX byte FIFO depth, power of two >= 2.
REQ-005 CLK100MHZ  input  1  system clock; all logic is on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 rx_pin_in  input  1  serial line in, asynchronous to the clock, idle high.
REQ-008 tx_pin_out  output  1  serial line out, idle high.
REQ-009 tx_word  input  8*WORD_BYTES  word to transmit; byte 0 = bits [7:0].
REQ-010 tx_len  input  LW  number of bytes of tx_word to send.
REQ-011 tx_valid  input  1  TX request.
REQ-012 tx_ready  output  1  TX engine idle and able to accept a word.
REQ-013 rx_data  output  8  head byte of the RX FIFO.
REQ-014 rx_valid  output  1  RX FIFO non-empty.
REQ-015 rx_ready  input  1  consumer pops the head byte.
REQ-016 rx_frame_err  output  1  one-cycle pulse for a bad stop bit.
REQ-017 rx_overflow  output  1  one-cycle pulse when a received byte is dropped because the FIFO is full.

Function
REQ-018 TX handshake SHALL accept a word when tx_valid & tx_ready are both high on a rising edge; tx_word and tx_len SHALL be captured that edge, and tx_ready SHALL drop the next cycle.
REQ-019 TX frame SHALL be 8N1 per byte: start 0, data LSB first, stop 1; each bit lasts exactly DIV clocks, and the start bit SHALL begin the cycle after acceptance.
REQ-020 TX byte order SHALL be byte 0 first through byte tx_len-1, back-to-back with no idle bit between bytes.
REQ-021 tx_len > WORD_BYTES SHALL be clamped to WORD_BYTES.
REQ-022 tx_len = 0 SHALL be accepted, send nothing, and raise tx_ready again the cycle after acceptance.
REQ-023 tx_ready SHALL rise the cycle after the last stop bit's DIV clocks complete.
REQ-024 TX FSM states SHALL be IDLE, START, DATA, STOP; transitions: IDLE->START on accept (len > 0); START->DATA after DIV clocks; DATA->STOP after 8 bits; STOP->START if bytes remain, else STOP->IDLE.
REQ-025 rx_pin_in SHALL pass through a 2-flop synchroniser before any use.
REQ-026 RX FSM states SHALL be IDLE, START, DATA, STOP; a falling edge in IDLE SHALL enter START.
REQ-027 In START, the synchronised line SHALL be sampled at DIV/2; if high, a glitch is declared and the FSM returns to IDLE with no byte and no error.
REQ-028 In DATA, 8 samples SHALL be taken, each DIV clocks apart, LSB first.
REQ-029 In STOP, the line SHALL be sampled once: 1 pushes the byte into the FIFO; 0 discards the byte and pulses rx_frame_err; either way the FSM returns to IDLE.
REQ-030 The RX FIFO SHALL be first-word-fall-through: rx_data is valid whenever rx_valid = 1, and a pop occurs on rx_valid & rx_ready.
REQ-031 RX FIFO pointers SHALL wrap modulo RX_DEPTH, with full/empty distinguished by an extra pointer bit.
REQ-032 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full, and the occupancy SHALL be unchanged.
REQ-033 A push to a full FIFO with no simultaneous pop SHALL drop the new byte and pulse rx_overflow; stored bytes SHALL be unchanged.
REQ-034 A pop while empty SHALL be ignored.
REQ-035 TX and RX SHALL operate fully independently; there is no loopback.

Reset
REQ-036 On rst_n low, both FSMs SHALL go to IDLE immediately, regardless of any frame in progress.
REQ-037 During reset, tx_pin_out=1, tx_ready=1, rx_valid=0, rx_data=8'h00, rx_frame_err=0 and rx_overflow=0; the FIFO SHALL be emptied and all counters cleared.
REQ-038 A frame interrupted by reset SHALL be abandoned, not resumed.
REQ-039 After release, RX SHALL ignore the line until the synchronised input is seen high, so no false start is taken from a line held low.
REQ-040 tx_ready SHALL be 1 in the first cycle after release.

Verification
All scenarios use CLK_HZ=100_000_000, BAUD=10_000_000 (DIV=10), WORD_BYTES=8, RX_DEPTH=4.
REQ-041 tx_word=64'h0807060504030201, tx_len=3 -> line carries bytes 01, 02, 03, 30 bits x 10 clocks = 300 cycles; tx_ready rises at cycle 301 after acceptance.
REQ-042 tx_len=0 and, separately, tx_len=12 -> no line activity with tx_ready back after 1 cycle; 8 bytes (80 bits) sent respectively.
REQ-043 Serial in 8'hA5 then 8'h3C with rx_ready=0 -> rx_valid=1, rx_data=A5; one pop gives 3C; a second pop gives rx_valid=0.
REQ-044 Five bytes in with rx_ready=0 -> one rx_overflow pulse and FIFO holds the first 4; repeat with a pop in the same cycle as the 5th push -> no overflow, FIFO holds bytes 2-5.
REQ-045 A 3-clock low glitch -> no byte; a frame with stop bit 0 -> rx_frame_err pulse and no push.
REQ-046 rst_n asserted mid-TX byte (bit 4) -> tx_pin_out=1 immediately; after release a new word transmits correctly.
